// File: rtl/icache_fetch_responder_pkg.sv
// Shared definitions for the instruction-cache fetch responder:
// refill FSM state encodings, default geometry and address helpers.
package icache_fetch_responder_pkg;

  // Refill FSM states; encodings are fixed so traces stay comparable across versions.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_FILL_DONE = 2'd2
  } state_e;

  // Default cache geometry.
  localparam int unsigned DEF_LINES          = 16;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_CNT_W          = 16;

  // Byte-offset bits inside a 32-bit word.
  localparam int unsigned BYTE_BITS = 2;

  // Clear the word and byte offset bits of an address, giving the line base.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned word_bits);
    logic [31:0] mask_s;
    mask_s = (32'd1 << (word_bits + BYTE_BITS)) - 32'd1;
    return addr & ~mask_s;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag / valid / data storage of the direct-mapped instruction cache.
// Combinational read port addressed by the fetch pc, one registered word
// write port for refill beats, a tag write, valid set/clear and a global
// clear used by flush. Tag and data arrays carry no reset.
module icache_line_store #(
  parameter  int unsigned LINES          = 16,
  parameter  int unsigned WORDS_PER_LINE = 4,
  parameter  int unsigned TAG_W          = 24,
  localparam int unsigned IB             = $clog2(LINES),
  localparam int unsigned WB             = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst_n,
  // read port
  input  logic [IB-1:0]     rd_index,
  input  logic [WB-1:0]     rd_word,
  output logic [31:0]       rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  // refill write port (word and tag share the line index)
  input  logic              wr_en,
  input  logic [IB-1:0]     wr_index,
  input  logic [WB-1:0]     wr_word,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  tag_data,
  // valid bit control
  input  logic              valid_set,
  input  logic              valid_clr,
  input  logic [IB-1:0]     valid_index,
  input  logic              clear_all
);

  logic [31:0]      data_r [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [LINES-1:0] valid_r;

  assign rd_data  = data_r[{rd_index, rd_word}];
  assign rd_tag   = tag_r[rd_index];
  assign rd_valid = valid_r[rd_index];

  // Refill writes into the data and tag arrays (no reset on the payload).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[{wr_index, wr_word}] <= wr_data;
    end
    if (tag_we) begin
      tag_r[wr_index] <= tag_data;
    end
  end

  // Valid bits: global clear beats a per-line clear, which beats a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (clear_all) begin
      valid_r <= '0;
    end else if (valid_clr) begin
      valid_r[valid_index] <= 1'b0;
    end else if (valid_set) begin
      valid_r[valid_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering the fetch stage.
// Lookup is combinational (hit/inst in the same cycle as pc); a miss starts
// a refill that reads the whole line one word per beat from instruction
// memory, then marks the line valid and returns to lookup.
module icache_fetch_responder
  import icache_fetch_responder_pkg::*;
#(
  parameter int unsigned LINES          = DEF_LINES,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  input  logic             fetch_en,
  input  logic             flush,
  output logic [31:0]      inst,
  output logic             hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_valid,
  output logic             busy,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned WB    = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB    = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - BYTE_BITS - WB - IB;
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

  // Address fields of the current fetch pc.
  logic [WB-1:0]    pc_word_s;
  logic [IB-1:0]    pc_index_s;
  logic [TAG_W-1:0] pc_tag_s;
  logic             pc_unused_s;

  assign pc_word_s   = pc[BYTE_BITS+WB-1:BYTE_BITS];
  assign pc_index_s  = pc[BYTE_BITS+WB+IB-1:BYTE_BITS+WB];
  assign pc_tag_s    = pc[31:BYTE_BITS+WB+IB];
  assign pc_unused_s = ^pc[BYTE_BITS-1:0];

  // Registered state.
  state_e           state_r;
  logic [WB-1:0]    beat_r;
  logic [31:0]      miss_addr_r;
  logic [CNT_W-1:0] miss_count_r;
  logic             mem_req_r;
  logic [31:0]      mem_addr_r;

  // Next-state values.
  state_e           state_nxt_s;
  logic [WB-1:0]    beat_nxt_s;
  logic [31:0]      miss_addr_nxt_s;
  logic [CNT_W-1:0] miss_count_nxt_s;
  logic             mem_req_nxt_s;
  logic [31:0]      mem_addr_nxt_s;

  // Line store interface.
  logic [31:0]      rd_data_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic             rd_valid_s;
  logic             wr_en_s;
  logic             tag_we_s;
  logic             valid_set_s;
  logic             valid_clr_s;
  logic [IB-1:0]    valid_index_s;
  logic [IB-1:0]    miss_index_s;
  logic [TAG_W-1:0] miss_tag_s;
  logic [WB-1:0]    beat_inc_s;
  logic             hit_s;

  assign miss_index_s = miss_addr_r[BYTE_BITS+WB+IB-1:BYTE_BITS+WB];
  assign miss_tag_s   = miss_addr_r[31:BYTE_BITS+WB+IB];
  assign beat_inc_s   = beat_r + {{(WB-1){1'b0}}, 1'b1};

  icache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_line_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index    (pc_index_s),
    .rd_word     (pc_word_s),
    .rd_data     (rd_data_s),
    .rd_tag      (rd_tag_s),
    .rd_valid    (rd_valid_s),
    .wr_en       (wr_en_s),
    .wr_index    (miss_index_s),
    .wr_word     (beat_r),
    .wr_data     (mem_rdata),
    .tag_we      (tag_we_s),
    .tag_data    (miss_tag_s),
    .valid_set   (valid_set_s),
    .valid_clr   (valid_clr_s),
    .valid_index (valid_index_s),
    .clear_all   (flush)
  );

  // Same-cycle lookup; only answers in IDLE and never while a flush is pending.
  assign hit_s = fetch_en & (state_r == ST_IDLE) & rd_valid_s
               & (rd_tag_s == pc_tag_s) & ~flush;

  assign hit        = hit_s;
  assign inst       = hit_s ? rd_data_s : 32'd0;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign busy       = (state_r != ST_IDLE);
  assign miss_count = miss_count_r;

  // Refill FSM next-state, memory request and line-store control.
  always_comb begin
    state_nxt_s      = state_r;
    beat_nxt_s       = beat_r;
    miss_addr_nxt_s  = miss_addr_r;
    miss_count_nxt_s = miss_count_r;
    mem_req_nxt_s    = mem_req_r;
    mem_addr_nxt_s   = mem_addr_r;
    wr_en_s          = 1'b0;
    tag_we_s         = 1'b0;
    valid_set_s      = 1'b0;
    valid_clr_s      = 1'b0;
    valid_index_s    = miss_index_s;

    case (state_r)
      ST_IDLE: begin
        valid_index_s = pc_index_s;
        if (flush) begin
          // A flush cancels any miss seen in the same cycle.
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
        end else if (fetch_en && !hit_s) begin
          miss_addr_nxt_s  = line_base(pc, WB);
          miss_count_nxt_s = (&miss_count_r) ? miss_count_r
                           : miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          valid_clr_s      = 1'b1;
          beat_nxt_s       = '0;
          mem_req_nxt_s    = 1'b1;
          mem_addr_nxt_s   = line_base(pc, WB);
          state_nxt_s      = ST_REFILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_REFILL: begin
        if (flush) begin
          // Abort: drop the request and any beat arriving this cycle.
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
          beat_nxt_s    = '0;
        end else if (mem_valid) begin
          wr_en_s = 1'b1;
          if (beat_r == LAST_BEAT) begin
            tag_we_s      = 1'b1;
            mem_req_nxt_s = 1'b0;
            beat_nxt_s    = '0;
            state_nxt_s   = ST_FILL_DONE;
          end else begin
            beat_nxt_s     = beat_inc_s;
            mem_addr_nxt_s = miss_addr_r
                           + {{(30-WB){1'b0}}, beat_inc_s, 2'b00};
          end
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end

      ST_FILL_DONE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else begin
          valid_set_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end
      end

      default: begin
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
        beat_nxt_s    = '0;
      end
    endcase
  end

  // FSM, refill bookkeeping, memory request and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      beat_r       <= '0;
      miss_addr_r  <= 32'd0;
      miss_count_r <= '0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      beat_r       <= beat_nxt_s;
      miss_addr_r  <= miss_addr_nxt_s;
      miss_count_r <= miss_count_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: cold miss and refill timing,
// same-line hits, conflict replacement, flush abort, slow memory with pc
// changes mid-refill, and asynchronous reset mid-refill.
module tb_icache_fetch_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] inst;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;
  logic [15:0] miss_count;

  int errors = 0;
  int checks = 0;

  icache_fetch_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .inst       (inst),
    .hit        (hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .busy       (busy),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: upper half fixed, lower half the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one line refill starting in the first REFILL cycle. Each beat waits
  // lat cycles with the request held, then returns data for one cycle.
  task automatic refill(input logic [31:0] base, input int first_lat, input int beat_lat);
    int lat;
    logic [31:0] a;
    for (int b = 0; b < 4; b++) begin
      lat = (b == 0) ? first_lat : beat_lat;
      a   = base + 32'(4 * b);
      for (int k = 0; k < lat; k++) begin
        mem_valid = 1'b0;
        #1;
        chk("wait_req", {31'd0, mem_req}, 32'd1);
        chk("wait_addr", mem_addr, a);
        step();
      end
      mem_valid = 1'b1;
      mem_rdata = mem_word(a);
      #1;
      chk("beat_req", {31'd0, mem_req}, 32'd1);
      chk("beat_addr", mem_addr, a);
      step();
      mem_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pc        = 32'd0;
    fetch_en  = 1'b0;
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 32'd0;
    #1;
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    #11;
    rst_n = 1'b1;
    step();

    // Test 1: cold miss at 0x100, 1-cycle memory, hit at cycle 7.
    pc       = 32'h0000_0100;
    fetch_en = 1'b1;
    #1;
    chk("t1_miss_hit", {31'd0, hit}, 32'd0);
    chk("t1_miss_inst", inst, 32'd0);
    chk("t1_miss_req0", {31'd0, mem_req}, 32'd0);
    step();
    #1;
    chk("t1_count", {16'd0, miss_count}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    refill(32'h0000_0100, 1, 0);
    #1;
    chk("t1_filldone_hit", {31'd0, hit}, 32'd0);
    chk("t1_filldone_req", {31'd0, mem_req}, 32'd0);
    chk("t1_filldone_busy", {31'd0, busy}, 32'd1);
    step();
    #1;
    chk("t1_c7_hit", {31'd0, hit}, 32'd1);
    chk("t1_c7_inst", inst, 32'hC0DE_0100);
    chk("t1_c7_busy", {31'd0, busy}, 32'd0);

    // Test 2: another word of the same line hits in the same cycle.
    pc = 32'h0000_0108;
    #1;
    chk("t2_hit", {31'd0, hit}, 32'd1);
    chk("t2_inst", inst, 32'hC0DE_0108);
    chk("t2_req", {31'd0, mem_req}, 32'd0);
    step();
    #1;
    chk("t2_no_refill", {31'd0, busy}, 32'd0);

    // fetch_en low: no hit, no miss.
    fetch_en = 1'b0;
    pc       = 32'h0000_0500;
    #1;
    chk("noen_hit", {31'd0, hit}, 32'd0);
    step();
    #1;
    chk("noen_busy", {31'd0, busy}, 32'd0);
    chk("noen_count", {16'd0, miss_count}, 32'd1);

    // Test 3: conflicting tag on index 0 replaces the line.
    fetch_en = 1'b1;
    pc       = 32'h0000_1100;
    #1;
    chk("t3_miss", {31'd0, hit}, 32'd0);
    step();
    #1;
    chk("t3_count", {16'd0, miss_count}, 32'd2);
    refill(32'h0000_1100, 1, 0);
    step();
    #1;
    chk("t3_hit", {31'd0, hit}, 32'd1);
    chk("t3_inst", inst, 32'hC0DE_1100);
    pc = 32'h0000_0100;
    #1;
    chk("t3_old_miss", {31'd0, hit}, 32'd0);
    step();
    #1;
    chk("t3_count3", {16'd0, miss_count}, 32'd3);
    chk("t3_addr", mem_addr, 32'h0000_0100);

    // Test 4: flush during the second refill beat aborts the refill.
    mem_valid = 1'b0;
    step();
    mem_valid = 1'b1;
    mem_rdata = mem_word(32'h0000_0100);
    step();
    mem_valid = 1'b1;
    mem_rdata = mem_word(32'h0000_0104);
    flush     = 1'b1;
    #1;
    chk("t4_beat1_addr", mem_addr, 32'h0000_0104);
    chk("t4_flush_hit", {31'd0, hit}, 32'd0);
    step();
    flush     = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("t4_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t4_busy_drop", {31'd0, busy}, 32'd0);
    chk("t4_line_invalid", {31'd0, hit}, 32'd0);
    step();
    #1;
    chk("t4_remiss_busy", {31'd0, busy}, 32'd1);
    chk("t4_count4", {16'd0, miss_count}, 32'd4);
    refill(32'h0000_0100, 1, 0);
    step();
    #1;
    chk("t4_refilled_inst", inst, 32'hC0DE_0100);

    // Flush coincident with a miss: no refill, count unchanged.
    pc    = 32'h0000_0600;
    flush = 1'b1;
    #1;
    chk("fm_hit", {31'd0, hit}, 32'd0);
    step();
    flush    = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("fm_busy", {31'd0, busy}, 32'd0);
    chk("fm_count", {16'd0, miss_count}, 32'd4);
    chk("fm_req", {31'd0, mem_req}, 32'd0);

    // Test 5: slow memory (5 cycles per beat), pc moves mid-refill.
    fetch_en = 1'b1;
    pc       = 32'h0000_0300;
    #1;
    chk("t5_miss", {31'd0, hit}, 32'd0);
    step();
    pc = 32'h0000_0200;
    #1;
    chk("t5_count", {16'd0, miss_count}, 32'd5);
    refill(32'h0000_0300, 5, 5);
    pc = 32'h0000_030C;
    #1;
    chk("t5_filldone_busy", {31'd0, busy}, 32'd1);
    step();
    #1;
    chk("t5_hit", {31'd0, hit}, 32'd1);
    chk("t5_inst", inst, 32'hC0DE_030C);
    pc = 32'h0000_0200;
    #1;
    chk("t5_other_tag_miss", {31'd0, hit}, 32'd0);

    // Test 6: asynchronous reset mid-refill.
    step();
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_addr0", mem_addr, 32'h0000_0200);
    step();
    mem_valid = 1'b1;
    mem_rdata = mem_word(32'h0000_0200);
    step();
    mem_valid = 1'b0;
    #1;
    chk("t6_addr1", mem_addr, 32'h0000_0204);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hit", {31'd0, hit}, 32'd0);
    chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_count", {16'd0, miss_count}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pc = 32'h0000_030C;
    #1;
    chk("t6_old_line_miss", {31'd0, hit}, 32'd0);
    step();
    #1;
    chk("t6_new_miss_busy", {31'd0, busy}, 32'd1);
    chk("t6_new_miss_count", {16'd0, miss_count}, 32'd1);
    fetch_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
